// File: rtl/fpmul_share_arbiter.sv
// Two-requester round-robin front end for one shared pipelined FP multiplier.
// Per-requester FWFT response FIFOs are guarded by issue credits. Define
// FPMUL_ARB_STATS_EN to add the grant/conflict statistics counters.
module fpmul_share_arbiter #(
  parameter int MUL_LAT   = 3,
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic [31:0] mul_op_a,
  output logic [31:0] mul_op_b,
  input  logic [31:0] mul_product,
  output logic        busy
`ifdef FPMUL_ARB_STATS_EN
  ,
  output logic [15:0] stat_grant0,
  output logic [15:0] stat_grant1,
  output logic [15:0] stat_conflict
`endif
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [1:0]       fifo_wr;
  logic [1:0]       fifo_pop;
  logic [1:0]       rsp_valid_w;
  logic [31:0]      rsp_data_w [2];
  logic             last_grant_reg;
  logic [MUL_LAT:0] tag_valid_reg;
  logic [MUL_LAT:0] tag_id_reg;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Grants are suppressed while reset is asserted so ready reads 0 in reset.
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (elig == 2'b11) grant = last_grant_reg ? 2'b01 : 2'b10;
      else               grant = elig;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // last_grant_reg resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      mul_op_a       <= '0;
      mul_op_b       <= '0;
      tag_valid_reg  <= '0;
      tag_id_reg     <= '0;
    end else begin
      if (|grant) begin
        last_grant_reg <= grant[1];
        mul_op_a       <= grant[1] ? req1_a : req0_a;
        mul_op_b       <= grant[1] ? req1_b : req0_b;
      end
      tag_valid_reg <= {tag_valid_reg[MUL_LAT-1:0], |grant};
      tag_id_reg    <= {tag_id_reg[MUL_LAT-1:0], grant[1]};
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic [31:0]   mem [RSP_DEPTH];
    logic [PW-1:0] wptr_reg;
    logic [PW-1:0] rptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] credit_reg;

    assign fifo_wr[gi]     = tag_valid_reg[MUL_LAT] && (tag_id_reg[MUL_LAT] == 1'(gi));
    assign rsp_valid_w[gi] = (count_reg != '0);
    assign fifo_pop[gi]    = rsp_valid_w[gi] & rsp_ready[gi];
    assign elig[gi]        = req_valid[gi] & (credit_reg != '0);
    assign rsp_data_w[gi]  = rsp_valid_w[gi] ? mem[rptr_reg] : '0;

    always_ff @(posedge clk) begin
      if (fifo_wr[gi]) mem[wptr_reg] <= mul_product;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr_reg   <= '0;
        rptr_reg   <= '0;
        count_reg  <= '0;
        credit_reg <= CW'(RSP_DEPTH);
      end else begin
        if (fifo_wr[gi])  wptr_reg <= wptr_reg + PW'(1);
        if (fifo_pop[gi]) rptr_reg <= rptr_reg + PW'(1);
        case ({fifo_wr[gi], fifo_pop[gi]})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
        // A credit is one FIFO slot not yet claimed by an issued operation.
        case ({grant[gi], fifo_pop[gi]})
          2'b10:   credit_reg <= credit_reg - CW'(1);
          2'b01:   credit_reg <= credit_reg + CW'(1);
          default: credit_reg <= credit_reg;
        endcase
      end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_wr[gi] && (count_reg == CW'(RSP_DEPTH))));
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
      credit_reg <= CW'(RSP_DEPTH));
  end

  assign rsp0_valid = rsp_valid_w[0];
  assign rsp1_valid = rsp_valid_w[1];
  assign rsp0_data  = rsp_data_w[0];
  assign rsp1_data  = rsp_data_w[1];
  assign busy       = (|tag_valid_reg) | (|rsp_valid_w);

`ifdef FPMUL_ARB_STATS_EN
  logic [15:0] stat_grant0_reg;
  logic [15:0] stat_grant1_reg;
  logic [15:0] stat_conflict_reg;
  logic        conflict_w;

  assign conflict_w = req0_valid & req1_valid & (grant[0] ^ grant[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant0_reg   <= '0;
      stat_grant1_reg   <= '0;
      stat_conflict_reg <= '0;
    end else begin
      if (grant[0] && (stat_grant0_reg != 16'hFFFF)) stat_grant0_reg <= stat_grant0_reg + 16'd1;
      if (grant[1] && (stat_grant1_reg != 16'hFFFF)) stat_grant1_reg <= stat_grant1_reg + 16'd1;
      if (conflict_w && (stat_conflict_reg != 16'hFFFF)) stat_conflict_reg <= stat_conflict_reg + 16'd1;
    end
  end

  assign stat_grant0   = stat_grant0_reg;
  assign stat_grant1   = stat_grant1_reg;
  assign stat_conflict = stat_conflict_reg;
`endif

endmodule

// File: tb/tb_fpmul_share_arbiter.sv
// Self-checking bench for fpmul_share_arbiter: behavioural 3-stage multiplier,
// per-requester scoreboards, a vector table and hand-timed corner sequences.
module tb_fpmul_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] mul_op_a, mul_op_b, mul_product;
  logic        busy;
`ifdef FPMUL_ARB_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  int passed = 0;
  int total  = 0;
  int pop0_cnt = 0, pop1_cnt = 0;
  logic [31:0] exp_q0[$], exp_q1[$], pop0_log[$];
  int grant_log[$];

  always #5 clk = ~clk;

  fpmul_share_arbiter #(.MUL_LAT(3), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .mul_op_a(mul_op_a), .mul_op_b(mul_op_b), .mul_product(mul_product),
    .busy(busy)
`ifdef FPMUL_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  // Normal-operand FP multiply with truncation; exact for the vectors used here.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] prod;
    logic [22:0] m;
    int e;
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      m = prod[46:24];
      e = e + 1;
    end else begin
      m = prod[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  // Multiplier model: operands captured one edge after issue, product 3 edges on.
  logic [31:0] p1, p2, p3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= '0; p2 <= '0; p3 <= '0;
    end else begin
      p1 <= fmul(mul_op_a, mul_op_b);
      p2 <= p1;
      p3 <= p2;
    end
  end
  assign mul_product = p3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passed++;
  endtask

  task automatic pop_check(input int n, input logic [31:0] data);
    logic [31:0] e;
    if (n == 0) begin
      pop0_cnt++;
      pop0_log.push_back(data);
      if (exp_q0.size() == 0) begin
        total++;
        $display("FAIL rsp0_unexpected actual=%h required=none", data);
      end else begin
        e = exp_q0.pop_front();
        chk("rsp0_data", data, e);
      end
    end else begin
      pop1_cnt++;
      if (exp_q1.size() == 0) begin
        total++;
        $display("FAIL rsp1_unexpected actual=%h required=none", data);
      end else begin
        e = exp_q1.pop_front();
        chk("rsp1_data", data, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (req0_valid && req0_ready) begin
        exp_q0.push_back(fmul(req0_a, req0_b));
        grant_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        exp_q1.push_back(fmul(req1_a, req1_b));
        grant_log.push_back(1);
      end
      if (req0_ready && req1_ready) begin
        total++;
        $display("FAIL one_ready actual=both required=at_most_one");
      end
      if (rsp0_valid && rsp0_ready) pop_check(0, rsp0_data);
      if (rsp1_valid && rsp1_ready) pop_check(1, rsp1_data);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    acc = 1'b0;
    if (n == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = (n == 0) ? req0_ready : req1_ready;
      tick();
      if (acc) break;
    end
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    chk("issue_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_rsp(input int n, input logic [31:0] exp, input string name);
    logic got;
    logic [31:0] d;
    got = 1'b0; d = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((n == 0) ? rsp0_valid : rsp1_valid) begin
        got = 1'b1;
        d = (n == 0) ? rsp0_data : rsp1_data;
        break;
      end
    end
    if (got) chk(name, d, exp);
    else begin
      total++;
      $display("FAIL %s actual=timeout required=%h", name, exp);
    end
    tick();
  endtask

  typedef struct {
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [6];
    logic r0, r1;
    int k0, k1, mism, ones;

    vt[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000};
    vt[1] = '{1, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
    vt[2] = '{0, 32'hC0000000, 32'h40800000, 32'hC1000000};
    vt[3] = '{1, 32'h3F000000, 32'h3F000000, 32'h3E800000};
    vt[4] = '{0, 32'h3F800000, 32'h3FC00000, 32'h3FC00000};
    vt[5] = '{1, 32'h3FC00000, 32'hBFC00000, 32'hC0100000};

    // Reset state, with requests asserted to show ready is held low.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_rsp_data", rsp0_data | rsp1_data, 32'd0);
    chk("rst_mul_op", mul_op_a | mul_op_b, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Full throughput straight out of reset.
    do_reset();
    grant_log.delete(); pop0_log.delete(); pop0_cnt = 0; pop1_cnt = 0;
    k0 = 0; k1 = 0;
    req0_a = 32'h3FC00000; req0_b = 32'h3FC00000;
    req1_a = 32'h40000000; req1_b = 32'h40400000;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
`ifdef FPMUL_ARB_STATS_EN
      if (c == 10) begin
        chk("stat_grant0", {16'd0, stat_grant0}, 32'd5);
        chk("stat_grant1", {16'd0, stat_grant1}, 32'd5);
        chk("stat_conflict", {16'd0, stat_conflict}, 32'd10);
      end
`endif
      r0 = req0_ready; r1 = req1_ready;
      tick();
      if (r0) begin k0++; req0_a = 32'h3FC00000 + (k0 << 19); end
      if (r1) begin k1++; req1_a = 32'h40000000 + (k1 << 18); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (12) tick();
    chk("tp_grant_count", grant_log.size(), 32'd16);
    mism = 0;
    for (int i = 0; i < grant_log.size(); i++) if (grant_log[i] != (i % 2)) mism++;
    chk("tp_alternate", mism, 32'd0);
    chk("tp_pops0", pop0_cnt, 32'd8);
    chk("tp_pops1", pop1_cnt, 32'd8);
    chk("tp_first_rsp0", (pop0_log.size() > 0) ? pop0_log[0] : 32'hDEADBEEF, 32'h40100000);
    chk("tp_idle", {31'd0, busy}, 32'd0);

    // Single op with exact latency: accept edge E0, rsp_valid after E4.
    req0_a = 32'h40000000; req0_b = 32'h40400000; req0_valid = 1'b1;
    @(negedge clk);
    chk("single_ready0", {31'd0, req0_ready}, 32'd1);
    chk("single_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("single_ready_drop", {31'd0, req0_ready}, 32'd0);
    chk("single_op_a", mul_op_a, 32'h40000000);
    chk("single_op_b", mul_op_b, 32'h40400000);
    chk("single_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("single_early", {31'd0, rsp0_valid}, 32'd0);
    end
    @(negedge clk);
    chk("single_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("single_data", rsp0_data, 32'h40C00000);
    chk("single_busy_held", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("single_busy_fall", {31'd0, busy}, 32'd0);
    tick();

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      issue(vt[i].n, vt[i].a, vt[i].b);
      wait_rsp(vt[i].n, vt[i].exp, "vec_product");
    end

    // Backpressure on requester 1.
    grant_log.delete();
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    req0_a = 32'h3F800000; req0_b = 32'h40000000;
    req1_a = 32'h40400000; req1_b = 32'h40400000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (20) tick();
    req0_valid = 1'b0;
    ones = 0; mism = 0;
    for (int i = 0; i < grant_log.size(); i++) begin
      if (grant_log[i] == 1) ones++;
      if (i >= 8 && grant_log[i] == 1) mism++;
    end
    chk("bp_grants1", ones, 32'd4);
    chk("bp_late_grants1", mism, 32'd0);
    repeat (3) tick();
    grant_log.delete();
    chk("bp_full_valid", {31'd0, rsp1_valid}, 32'd1);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    repeat (10) tick();
    chk("bp_one_more_count", grant_log.size(), 32'd1);
    chk("bp_one_more_id", (grant_log.size() > 0) ? grant_log[0] : -1, 32'd1);
    req1_valid = 1'b0; rsp1_ready = 1'b1;
    repeat (12) tick();
    chk("bp_idle", {31'd0, busy}, 32'd0);

    // Grant and pop on the same edge with one credit left.
    rsp0_ready = 1'b0;
    issue(0, 32'h40000000, 32'h40000000);
    issue(0, 32'h40400000, 32'h40000000);
    issue(0, 32'h40800000, 32'h40000000);
    repeat (6) tick();
    req0_a = 32'h3F800000; req0_b = 32'h3F800000;
    req0_valid = 1'b1; rsp0_ready = 1'b1;
    @(negedge clk);
    chk("sim_grant", {31'd0, req0_ready}, 32'd1);
    chk("sim_pop", {31'd0, rsp0_valid}, 32'd1);
    tick();
    rsp0_ready = 1'b0;
    @(negedge clk);
    chk("sim_credit_kept", {31'd0, req0_ready}, 32'd1);
    tick();
    @(negedge clk);
    chk("sim_credit_out", {31'd0, req0_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    repeat (14) tick();
    chk("sim_idle", {31'd0, busy}, 32'd0);

    // Reset with three ops in flight.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    issue(0, 32'h40000000, 32'h40400000);
    issue(1, 32'h3FC00000, 32'h3FC00000);
    issue(0, 32'h40400000, 32'h40400000);
    chk("mr_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    pop0_cnt = 0; pop1_cnt = 0;
    issue(1, 32'h40400000, 32'h40400000);
    wait_rsp(1, 32'h41100000, "mr_own_result");
    repeat (10) tick();
    chk("mr_pops0", pop0_cnt, 32'd0);
    chk("mr_pops1", pop1_cnt, 32'd1);
    chk("mr_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fpmul_share_arbiter.md
Name: fpmul_share_arbiter

Overview:
- Shares one 3-stage pipelined single-precision FP multiplier between two requesters.
- Round-robin arbitration with one issue per cycle, back-to-back.
- A tag pipeline tracks which requester owns each in-flight product.
- Results are steered into per-requester response FIFOs; credit counters guarantee a FIFO slot exists before an operation is issued.

Parameters:
- MUL_LAT, 3, multiplier latency in clk edges from operand capture to valid product.
- RSP_DEPTH, 4, entries per response FIFO (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req0_valid  in  1  requester 0 operand pair valid.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req0_a  in  32  requester 0 operand A (IEEE-754 single).
- req0_b  in  32  requester 0 operand B.
- req1_valid, req1_ready, req1_a, req1_b  same widths/meaning for requester 1.
- rsp0_valid  out  1  requester 0 result available.
- rsp0_ready  in  1  requester 0 pops result.
- rsp0_data  out  32  requester 0 product.
- rsp1_valid, rsp1_ready, rsp1_data  same for requester 1.
- mul_op_a  out  32  registered operand A to multiplier.
- mul_op_b  out  32  registered operand B to multiplier.
- mul_product  in  32  multiplier result.
- busy  out  1  any op in flight or any FIFO non-empty.

Behaviour:
- Reset values: req*_ready=0, rsp*_valid=0, rsp*_data=0, mul_op_a/b=0, busy=0. Credits=RSP_DEPTH each, tag pipeline all invalid, FIFOs empty, rr pointer set so requester 0 wins first tie.
- Eligibility: eligN = reqN_valid & (creditN != 0).
- Grant: combinational.
  - Only one eligible requester: grant it.
  - Both eligible: grant the one not granted last; rr pointer updates only on a grant.
  - reqN_ready = grantN. At most one ready per cycle.
- Issue: on the grant edge, mul_op_a/b <= winner's operands and tag stage 0 <= {valid=1, id=N}. With no grant, mul_op_a/b hold and tag stage 0 valid=0.
- Tag pipeline: MUL_LAT further register stages. The tag at stage MUL_LAT aligns with mul_product.
  - If that tag is valid, mul_product is written to FIFO[id] on the next edge.
  - Accept-to-rsp_valid latency is MUL_LAT+1 = 4 edges.
- Credits:
  - Decrement on grant; increment on rspN_valid & rspN_ready.
  - Both in the same cycle: unchanged.
  - Never exceeds RSP_DEPTH and never underflows. FIFO overflow is impossible by construction; an assertion checks this.
- FIFO: first-word-fall-through. rspN_data is valid whenever rspN_valid=1. Simultaneous write and pop on an empty FIFO: rsp_valid stays 0 that cycle and the written data appears next cycle. Pointers wrap modulo RSP_DEPTH.
- Ordering: per-requester results return in issue order. No ordering is defined across requesters.
- Full throughput: with both requesters always valid and always popping, grants alternate 0,1,0,1 with one issue every cycle.
- Backpressure: if a requester never pops, it stops being granted after RSP_DEPTH issues. The other requester then receives every grant.
- Special values (NaN/Inf/underflow) pass through unmodified; the arbiter never inspects the data.
- Reset mid-operation: all in-flight tags and FIFO contents are discarded and credits restored. The multiplier shares rst_n, so no stale product can be captured.
- busy = any tag valid | any FIFO non-empty.

Optional Feature:
- Macro: FPMUL_ARB_STATS_EN.
- Enabled:
  - Adds outputs stat_grant0 [15:0], stat_grant1 [15:0] and stat_conflict [15:0].
  - stat_grantN counts grants to requester N.
  - stat_conflict counts cycles where both requesters were valid and only one was granted.
  - All three saturate at 0xFFFF and reset to 0.
- Disabled: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single op: req0 2.0×3.0 (0x40000000, 0x40400000) with rsp0_ready=1 → req0_ready high 1 cycle; rsp0_valid 4 edges later with data 0x40C00000; busy falls the cycle after the pop.
- Both valid every cycle with distinct operand pairs → grants alternate starting with req0. rsp0 and rsp1 each receive one result every 2 cycles in issue order, e.g. 1.5×1.5=0x40100000 on rsp0.
- rsp1_ready=0, req1 always valid → exactly 4 grants to req1, then req1_ready stays 0. Popping one entry restores exactly one grant.
- Simultaneous grant and pop on req0 with credit=1 → credit stays 1 and the grant proceeds; no FIFO overflow assertion fires.
- Assert rst_n low with 3 ops in flight → all rsp*_valid=0 and busy=0 immediately. After release, a new op returns only its own result.
- With FPMUL_ARB_STATS_EN: 10 cycles of both valid and both always popping → stat_grant0=5, stat_grant1=5, stat_conflict=10.
